// File: rtl/decode_stage.sv
// RV32I/RV64I (+optional M) decode stage with registered output and a 2-entry skid buffer.
// Latency 1 cycle; o_Ready is registered as !skid_full so fetch stalls one entry early without loss.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Flush,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [31:0]     i_InstructionWord,
  input  logic [XLEN-1:0] i_Pc,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_Pc,
  output logic [XLEN-1:0] o_Immediate,
  output logic [4:0]      o_Rs1,
  output logic [4:0]      o_Rs2,
  output logic [4:0]      o_Rd,
  output logic [2:0]      o_AluOp,
  output logic            o_AluOpAlt,
  output logic [1:0]      o_AluSrc1,
  output logic [1:0]      o_AluSrc2,
  output logic            o_MemRead,
  output logic            o_MemWrite,
  output logic [2:0]      o_MemMode,
  output logic            o_RegWrite,
  output logic            o_WbSrc,
  output logic            o_Jump,
  output logic            o_Branch,
  output logic            o_Jalr,
  output logic            o_MulDiv,
  output logic            o_Word,
  output logic            o_Exception,
  output logic [3:0]      o_Cause
);

  localparam logic RV64 = (XLEN == 64);
  localparam logic M_EN = (ENABLE_M != 0);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      alu_op;
    logic            alu_op_alt;
    logic [1:0]      alu_src1;
    logic [1:0]      alu_src2;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_mode;
    logic            reg_write;
    logic            wb_src;
    logic            jump;
    logic            branch;
    logic            jalr;
    logic            mul_div;
    logic            word;
    logic            exception;
    logic [3:0]      cause;
  } dec_t;

  logic [31:0] w;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  assign w   = i_InstructionWord;
  assign opc = w[6:0];
  assign f7  = w[31:25];
  assign f3  = w[14:12];

  dec_t               d;
  logic               illegal;
  logic               ecall;
  logic               ebreak;
  logic signed [31:0] imm32;

  always_comb begin
    d          = '0;
    illegal    = 1'b0;
    ecall      = 1'b0;
    ebreak     = 1'b0;
    imm32      = '0;
    d.pc       = i_Pc;
    d.rs1      = w[19:15];
    d.rs2      = w[24:20];
    d.rd       = w[11:7];
    d.alu_op   = f3;
    case (opc)
      7'b0000011: begin // LOAD
        imm32      = {{20{w[31]}}, w[31:20]};
        d.alu_op   = 3'b000;
        d.alu_src2 = 2'd1;
        d.mem_read = 1'b1;
        d.mem_mode = f3;
        d.reg_write = 1'b1;
        d.wb_src   = 1'b1;
        illegal    = (f3 == 3'b111) || (!RV64 && (f3 == 3'b110 || f3 == 3'b011));
      end
      7'b0100011: begin // STORE
        imm32       = {{20{w[31]}}, w[31:25], w[11:7]};
        d.alu_op    = 3'b000;
        d.alu_src2  = 2'd1;
        d.mem_write = 1'b1;
        d.mem_mode  = f3;
        illegal     = f3[2] || (!RV64 && f3 == 3'b011);
      end
      7'b1100011: begin // BRANCH
        imm32    = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        d.alu_op = 3'b000;
        d.branch = 1'b1;
        illegal  = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b1100111: begin // JALR
        imm32       = {{20{w[31]}}, w[31:20]};
        d.alu_op    = 3'b000;
        d.alu_src1  = 2'd1;
        d.alu_src2  = 2'd2;
        d.reg_write = 1'b1;
        d.jump      = 1'b1;
        d.jalr      = 1'b1;
        illegal     = (f3 != 3'b000);
      end
      7'b1101111: begin // JAL
        imm32       = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        d.alu_op    = 3'b000;
        d.alu_src1  = 2'd1;
        d.alu_src2  = 2'd2;
        d.reg_write = 1'b1;
        d.jump      = 1'b1;
      end
      7'b0110111, 7'b0010111: begin // LUI / AUIPC: result is src1 + upper immediate
        imm32       = {w[31:12], 12'b0};
        d.alu_op    = 3'b000;
        d.alu_src1  = opc[5] ? 2'd2 : 2'd1;
        d.alu_src2  = 2'd1;
        d.reg_write = 1'b1;
      end
      7'b0010011: begin // OP-IMM
        imm32       = {{20{w[31]}}, w[31:20]};
        d.alu_src2  = 2'd1;
        d.reg_write = 1'b1;
        if (f3 == 3'b001)
          illegal = !(f7 == 7'b0 || (RV64 && f7[6:1] == 6'b0));
        if (f3 == 3'b101) begin
          d.alu_op_alt = w[30];
          illegal = !(f7 == 7'b0 || f7 == 7'b0100000 ||
                      (RV64 && (f7[6:1] == 6'b0 || f7[6:1] == 6'b010000)));
        end
      end
      7'b0011011: begin // OP-IMM-32
        imm32        = {{20{w[31]}}, w[31:20]};
        d.alu_src2   = 2'd1;
        d.reg_write  = 1'b1;
        d.word       = RV64;
        d.alu_op_alt = (f3 == 3'b101) && w[30];
        illegal = !RV64 || !((f3 == 3'b000) || (f3 == 3'b001 && f7 == 7'b0) ||
                             (f3 == 3'b101 && (f7 == 7'b0 || f7 == 7'b0100000)));
      end
      7'b0110011, 7'b0111011: begin // OP / OP-32
        d.reg_write = 1'b1;
        d.word      = opc[3] && RV64;
        case (f7)
          7'b0000000: illegal = opc[3] && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
          7'b0100000: begin
            d.alu_op_alt = 1'b1;
            illegal = !(f3 == 3'b000 || f3 == 3'b101);
          end
          7'b0000001: begin
            d.mul_div = 1'b1;
            illegal = !M_EN || (opc[3] && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011));
          end
          default: illegal = 1'b1;
        endcase
        if (opc[3] && !RV64)
          illegal = 1'b1;
      end
      7'b1110011: begin // SYSTEM: only ECALL/EBREAK, no CSRs
        if (w == 32'h0000_0073)      ecall   = 1'b1;
        else if (w == 32'h0010_0073) ebreak  = 1'b1;
        else                         illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (w[1:0] != 2'b11)
      illegal = 1'b1;
    d.imm = XLEN'(imm32);
    if (illegal || ecall || ebreak) begin
      d.exception = 1'b1;
      d.cause     = illegal ? 4'd2 : (ecall ? 4'd11 : 4'd3);
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
      d.jump      = 1'b0;
      d.branch    = 1'b0;
      d.jalr      = 1'b0;
      d.mul_div   = 1'b0;
    end
  end

  dec_t e0, e1;
  logic v0, v1, rdy;
  logic in_fire, out_fire;
  assign in_fire  = i_Valid && rdy;
  assign out_fire = v0 && i_Ready;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      e0  <= '0;
      e1  <= '0;
      v0  <= 1'b0;
      v1  <= 1'b0;
      rdy <= 1'b0;
    end else if (i_Flush) begin
      v0  <= 1'b0;
      v1  <= 1'b0;
      rdy <= 1'b1;
    end else if (!v0 || out_fire) begin
      // entry 0 is free this cycle: refill from skid first to keep order
      if (v1) begin
        e0  <= e1;
        v0  <= 1'b1;
        if (in_fire) e1 <= d;
        v1  <= in_fire;
        rdy <= !in_fire;
      end else begin
        if (in_fire) e0 <= d;
        v0  <= in_fire;
        rdy <= 1'b1;
      end
    end else if (in_fire) begin
      e1  <= d;
      v1  <= 1'b1;
      rdy <= 1'b0;
    end
  end

  assign o_Ready     = rdy;
  assign o_Valid     = v0;
  assign o_Pc        = e0.pc;
  assign o_Immediate = e0.imm;
  assign o_Rs1       = e0.rs1;
  assign o_Rs2       = e0.rs2;
  assign o_Rd        = e0.rd;
  assign o_AluOp     = e0.alu_op;
  assign o_AluOpAlt  = e0.alu_op_alt;
  assign o_AluSrc1   = e0.alu_src1;
  assign o_AluSrc2   = e0.alu_src2;
  assign o_MemRead   = e0.mem_read;
  assign o_MemWrite  = e0.mem_write;
  assign o_MemMode   = e0.mem_mode;
  assign o_RegWrite  = e0.reg_write;
  assign o_WbSrc     = e0.wb_src;
  assign o_Jump      = e0.jump;
  assign o_Branch    = e0.branch;
  assign o_Jalr      = e0.jalr;
  assign o_MulDiv    = e0.mul_div;
  assign o_Word      = e0.word;
  assign o_Exception = e0.exception;
  assign o_Cause     = e0.cause;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32), one instance per ENABLE_M setting sharing inputs.
module tb_decode_stage;
  logic        i_Clock = 1'b0;
  logic        i_Reset, i_Flush, i_Valid, i_Ready;
  logic [31:0] i_InstructionWord, i_Pc;

  logic        o_Ready, o_Valid, o_AluOpAlt, o_MemRead, o_MemWrite, o_RegWrite, o_WbSrc;
  logic        o_Jump, o_Branch, o_Jalr, o_MulDiv, o_Word, o_Exception;
  logic [31:0] o_Pc, o_Immediate;
  logic [4:0]  o_Rs1, o_Rs2, o_Rd;
  logic [2:0]  o_AluOp, o_MemMode;
  logic [1:0]  o_AluSrc1, o_AluSrc2;
  logic [3:0]  o_Cause;

  logic        m_Ready, m_Valid, m_AluOpAlt, m_MemRead, m_MemWrite, m_RegWrite, m_WbSrc;
  logic        m_Jump, m_Branch, m_Jalr, m_MulDiv, m_Word, m_Exception;
  logic [31:0] m_Pc, m_Immediate;
  logic [4:0]  m_Rs1, m_Rs2, m_Rd;
  logic [2:0]  m_AluOp, m_MemMode;
  logic [1:0]  m_AluSrc1, m_AluSrc2;
  logic [3:0]  m_Cause;

  int checks = 0;
  int failures = 0;

  always #5 i_Clock = ~i_Clock;

  decode_stage #(.XLEN(32), .ENABLE_M(0)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Flush(i_Flush), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_InstructionWord(i_InstructionWord), .i_Pc(i_Pc), .o_Valid(o_Valid), .i_Ready(i_Ready),
    .o_Pc(o_Pc), .o_Immediate(o_Immediate), .o_Rs1(o_Rs1), .o_Rs2(o_Rs2), .o_Rd(o_Rd),
    .o_AluOp(o_AluOp), .o_AluOpAlt(o_AluOpAlt), .o_AluSrc1(o_AluSrc1), .o_AluSrc2(o_AluSrc2),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_MemMode(o_MemMode), .o_RegWrite(o_RegWrite),
    .o_WbSrc(o_WbSrc), .o_Jump(o_Jump), .o_Branch(o_Branch), .o_Jalr(o_Jalr), .o_MulDiv(o_MulDiv),
    .o_Word(o_Word), .o_Exception(o_Exception), .o_Cause(o_Cause));

  decode_stage #(.XLEN(32), .ENABLE_M(1)) dut_m (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Flush(i_Flush), .i_Valid(i_Valid), .o_Ready(m_Ready),
    .i_InstructionWord(i_InstructionWord), .i_Pc(i_Pc), .o_Valid(m_Valid), .i_Ready(i_Ready),
    .o_Pc(m_Pc), .o_Immediate(m_Immediate), .o_Rs1(m_Rs1), .o_Rs2(m_Rs2), .o_Rd(m_Rd),
    .o_AluOp(m_AluOp), .o_AluOpAlt(m_AluOpAlt), .o_AluSrc1(m_AluSrc1), .o_AluSrc2(m_AluSrc2),
    .o_MemRead(m_MemRead), .o_MemWrite(m_MemWrite), .o_MemMode(m_MemMode), .o_RegWrite(m_RegWrite),
    .o_WbSrc(m_WbSrc), .o_Jump(m_Jump), .o_Branch(m_Branch), .o_Jalr(m_Jalr), .o_MulDiv(m_MulDiv),
    .o_Word(m_Word), .o_Exception(m_Exception), .o_Cause(m_Cause));

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] word, input logic [31:0] pc);
    i_Valid = 1'b1;
    i_InstructionWord = word;
    i_Pc = pc;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Flush = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1;
    i_InstructionWord = 32'h0; i_Pc = 32'h0;
    step();
    step();
    checks++;
    if ({o_Valid, o_Ready} !== 2'b00) begin
      failures++; $display("FAIL reset_vld_rdy got=%b exp=00", {o_Valid, o_Ready});
    end
    checks++;
    if ({o_Pc, o_Immediate, o_Cause, o_RegWrite, o_AluSrc2} !== 71'h0) begin
      failures++; $display("FAIL reset_fields got pc=%h imm=%h cause=%0d exp all 0", o_Pc, o_Immediate, o_Cause);
    end
    i_Reset = 1'b0;
    step();
    checks++;
    if ({o_Valid, o_Ready} !== 2'b01) begin
      failures++; $display("FAIL reset_release got=%b exp=01", {o_Valid, o_Ready});
    end
  endtask

  task automatic test_addi();
    drive(32'hFFF1_0093, 32'h100);
    step();
    i_Valid = 1'b0;
    checks++;
    if ({o_Valid, o_Rd, o_Rs1, o_Pc} !== {1'b1, 5'd1, 5'd2, 32'h100}) begin
      failures++; $display("FAIL addi_regs got v=%b rd=%0d rs1=%0d pc=%h exp v=1 rd=1 rs1=2 pc=100", o_Valid, o_Rd, o_Rs1, o_Pc);
    end
    checks++;
    if ({o_Immediate, o_AluSrc2, o_RegWrite, o_AluOpAlt, o_Exception} !== {32'hFFFF_FFFF, 2'd1, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL addi_ctrl got imm=%h src2=%0d rw=%b alt=%b exc=%b exp imm=ffffffff src2=1 rw=1 alt=0 exc=0",
                           o_Immediate, o_AluSrc2, o_RegWrite, o_AluOpAlt, o_Exception);
    end
    step();
    checks++;
    if (o_Valid !== 1'b0) begin
      failures++; $display("FAIL addi_drain got=%b exp=0", o_Valid);
    end
  endtask

  task automatic test_jalr();
    drive(32'h0082_80E7, 32'h140);
    step();
    i_Valid = 1'b0;
    checks++;
    if ({o_Valid, o_Jump, o_Jalr, o_Branch, o_RegWrite, o_Exception} !== 6'b111010) begin
      failures++; $display("FAIL jalr_flags got=%b exp=111010", {o_Valid, o_Jump, o_Jalr, o_Branch, o_RegWrite, o_Exception});
    end
    checks++;
    if ({o_Immediate, o_AluSrc1, o_AluSrc2, o_AluOp, o_Rs1, o_Rd} !== {32'd8, 2'd1, 2'd2, 3'd0, 5'd5, 5'd1}) begin
      failures++; $display("FAIL jalr_fields got imm=%h src1=%0d src2=%0d op=%0d rs1=%0d rd=%0d exp imm=8 src1=1 src2=2 op=0 rs1=5 rd=1",
                           o_Immediate, o_AluSrc1, o_AluSrc2, o_AluOp, o_Rs1, o_Rd);
    end
    step();
  endtask

  task automatic test_mul();
    drive(32'h0220_81B3, 32'h180);
    step();
    i_Valid = 1'b0;
    checks++;
    if ({m_Valid, m_MulDiv, m_Exception, m_RegWrite, m_Cause, m_AluOp, m_Rd, m_Rs1, m_Rs2} !==
        {1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2}) begin
      failures++; $display("FAIL mul_enabled got md=%b exc=%b rw=%b cause=%0d rd=%0d exp md=1 exc=0 rw=1 cause=0 rd=3",
                           m_MulDiv, m_Exception, m_RegWrite, m_Cause, m_Rd);
    end
    checks++;
    if ({o_Valid, o_MulDiv, o_Exception, o_RegWrite, o_Cause} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd2}) begin
      failures++; $display("FAIL mul_disabled got md=%b exc=%b rw=%b cause=%0d exp md=0 exc=1 rw=0 cause=2",
                           o_MulDiv, o_Exception, o_RegWrite, o_Cause);
    end
    step();
  endtask

  // back-to-back stream with i_Ready=1; each row is checked one cycle after it is driven
  task automatic test_back_to_back();
    logic [31:0] tw [9];
    logic        te [9];
    logic [3:0]  tc [9];
    logic        tr [9];
    logic        ta [9];
    tw = '{32'h0000_0073, 32'h0010_0073, 32'h0000_0000, 32'h0200_9093, 32'h4030_D093,
           32'h4020_81B3, 32'h4020_91B3, 32'h0000_B083, 32'h0000_A083};
    te = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tc = '{4'd11, 4'd3, 4'd2, 4'd2, 4'd0, 4'd0, 4'd2, 4'd2, 4'd0};
    tr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ta = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    i_Ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(tw[i], 32'h300 + 32'(4 * i));
      step();
      checks++;
      if ({o_Valid, o_Pc, o_Exception, o_Cause, o_RegWrite, o_Ready} !==
          {1'b1, 32'h300 + 32'(4 * i), te[i], tc[i], tr[i], 1'b1}) begin
        failures++; $display("FAIL stream_%0d got v=%b pc=%h exc=%b cause=%0d rw=%b rdy=%b exp v=1 pc=%h exc=%b cause=%0d rw=%b rdy=1",
                             i, o_Valid, o_Pc, o_Exception, o_Cause, o_RegWrite, o_Ready,
                             32'h300 + 32'(4 * i), te[i], tc[i], tr[i]);
      end
      if (!te[i]) begin
        checks++;
        if (o_AluOpAlt !== ta[i]) begin
          failures++; $display("FAIL stream_alt_%0d got=%b exp=%b", i, o_AluOpAlt, ta[i]);
        end
      end
    end
    i_Valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic [32:0] exp_vp [6];
    logic        exp_rdy [6];
    exp_vp  = '{{1'b1, 32'h200}, {1'b1, 32'h200}, {1'b1, 32'h200},
                {1'b1, 32'h204}, {1'b1, 32'h208}, {1'b0, 32'h208}};
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    i_Ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(32'h0010_0093 + (32'(i) << 20), 32'h200 + 32'(4 * i));
      if (i == 3) i_Ready = 1'b1;
      step();
      if (i == 4) i_Valid = 1'b0;
      if (exp_vp[i][32] == 1'b0) begin
        checks++;
        if (o_Valid !== 1'b0) begin
          failures++; $display("FAIL stall_%0d got v=%b exp v=0", i, o_Valid);
        end
      end else begin
        checks++;
        if ({o_Valid, o_Pc} !== exp_vp[i]) begin
          failures++; $display("FAIL stall_%0d got v=%b pc=%h exp v=1 pc=%h", i, o_Valid, o_Pc, exp_vp[i][31:0]);
        end
      end
      checks++;
      if (o_Ready !== exp_rdy[i]) begin
        failures++; $display("FAIL stall_rdy_%0d got=%b exp=%b", i, o_Ready, exp_rdy[i]);
      end
      if (i == 2) begin
        checks++;
        if (o_Immediate !== 32'd1) begin
          failures++; $display("FAIL stall_hold_imm got=%h exp=1", o_Immediate);
        end
      end
    end
  endtask

  task automatic test_flush();
    i_Ready = 1'b0;
    drive(32'h0010_0093, 32'h400);
    step();
    drive(32'h0020_0093, 32'h404);
    step();
    drive(32'h0030_0093, 32'h408);
    i_Flush = 1'b1;
    step();
    i_Flush = 1'b0;
    i_Valid = 1'b0;
    checks++;
    if ({o_Valid, o_Ready} !== 2'b01) begin
      failures++; $display("FAIL flush_state got v/rdy=%b exp=01", {o_Valid, o_Ready});
    end
    i_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o_Valid !== 1'b0) begin
        failures++; $display("FAIL flush_leak_%0d got v=%b pc=%h exp v=0", i, o_Valid, o_Pc);
      end
    end
    drive(32'h0040_0093, 32'h40C);
    i_Flush = 1'b1;
    step();
    i_Flush = 1'b0;
    i_Valid = 1'b0;
    checks++;
    if ({o_Valid, o_Ready} !== 2'b01) begin
      failures++; $display("FAIL flush_drop_input got v/rdy=%b exp=01", {o_Valid, o_Ready});
    end
  endtask

  task automatic test_reset_mid_stall();
    i_Ready = 1'b0;
    drive(32'h0010_0093, 32'h500);
    step();
    drive(32'h0020_0093, 32'h504);
    step();
    i_Valid = 1'b0;
    i_Reset = 1'b1;
    step();
    checks++;
    if ({o_Valid, o_Ready, o_Pc, o_RegWrite} !== {2'b00, 32'h0, 1'b0}) begin
      failures++; $display("FAIL rst_stall got v=%b rdy=%b pc=%h rw=%b exp v=0 rdy=0 pc=0 rw=0", o_Valid, o_Ready, o_Pc, o_RegWrite);
    end
    i_Reset = 1'b0;
    i_Ready = 1'b1;
    step();
    checks++;
    if ({o_Valid, o_Ready} !== 2'b01) begin
      failures++; $display("FAIL rst_stall_release got=%b exp=01", {o_Valid, o_Ready});
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_jalr();
    test_mul();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
